// File: rtl/sel_enc_regfile_pkg.sv
// rtl/sel_enc_regfile_pkg.sv - shared widths and IR register-field positions for sel_enc_regfile
package sel_enc_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int C_W    = 19;

    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

endpackage

// File: rtl/sel_enc_decode.sv
// rtl/sel_enc_decode.sv - G-gated register index decode, one-hot drive selects and C sign extension
module sel_enc_decode
    import sel_enc_regfile_pkg::*;
(
    input  logic [31:0]       ir,
    input  logic              gra,
    input  logic              grb,
    input  logic              grc,
    input  logic              rout,
    input  logic              baout,
    output logic [3:0]        idx,
    output logic [NREG-1:0]   dec,
    output logic [NREG-1:0]   r_out_sel,
    output logic [DATA_W-1:0] c_sign
);

    // Opcode bits are not part of register selection.
    logic unused_ir;
    assign unused_ir = ^ir[31:27];

    always_comb begin
        // With no G line asserted idx falls to 0 and selects R0 by design.
        idx = (ir[RA_MSB:RA_LSB] & {4{gra}})
            | (ir[RB_MSB:RB_LSB] & {4{grb}})
            | (ir[RC_MSB:RC_LSB] & {4{grc}});
        dec      = '0;
        dec[idx] = 1'b1;
        r_out_sel = dec & {NREG{rout | baout}};
        c_sign    = {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]};
    end

endmodule

// File: rtl/sel_enc_regfile.sv
// rtl/sel_enc_regfile.sv - GPR file R0..R15 with bus load, drive selects and sel_err (SEL_ENC_CONFLICT_CHECK_EN)
module sel_enc_regfile
    import sel_enc_regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   clr,
    input  logic [DATA_W-1:0]      bus_in,
    input  logic [31:0]            ir,
    input  logic                   gra,
    input  logic                   grb,
    input  logic                   grc,
    input  logic                   rin,
    input  logic                   rout,
    input  logic                   baout,
    output logic [NREG*DATA_W-1:0] reg_q,
    output logic [NREG-1:0]        r_out_sel,
    output logic [DATA_W-1:0]      c_sign,
    output logic                   sel_err
);

    logic [3:0]        idx;
    logic [NREG-1:0]   dec;
    logic [DATA_W-1:0] regs [NREG];

    sel_enc_decode u_decode (
        .ir        (ir),
        .gra       (gra),
        .grb       (grb),
        .grc       (grc),
        .rout      (rout),
        .baout     (baout),
        .idx       (idx),
        .dec       (dec),
        .r_out_sel (r_out_sel),
        .c_sign    (c_sign)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (rin) begin
            regs[idx] <= bus_in;
        end
    end

    // BAout masks only the visible R0 slice; the stored R0 is untouched.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NREG; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs[i];
        end
        if (baout && dec[0]) begin
            reg_q[DATA_W-1:0] = '0;
        end
    end

`ifdef SEL_ENC_CONFLICT_CHECK_EN
    logic sel_err_q;
    logic multi_g;

    assign multi_g = (gra & grb) | (gra & grc) | (grb & grc);

    always_ff @(posedge clk) begin
        if (clr) begin
            sel_err_q <= 1'b0;
        end else if (((rin | rout | baout) & multi_g) | (rout & baout)) begin
            sel_err_q <= 1'b1;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_enc_regfile.sv
// tb/tb_sel_enc_regfile.sv - directed table and sequence bench for sel_enc_regfile
module tb_sel_enc_regfile;

    localparam int DW = 32;
    localparam int NR = 16;
`ifdef SEL_ENC_CONFLICT_CHECK_EN
    localparam logic CONF = 1'b1;
`else
    localparam logic CONF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic [DW-1:0]     bus_in;
    logic [31:0]       ir;
    logic              gra, grb, grc, rin, rout, baout;
    logic [NR*DW-1:0]  reg_q;
    logic [NR-1:0]     r_out_sel;
    logic [DW-1:0]     c_sign;
    logic              sel_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [DW-1:0] model [NR];

    sel_enc_regfile dut (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .ir        (ir),
        .gra       (gra),
        .grb       (grb),
        .grc       (grc),
        .rin       (rin),
        .rout      (rout),
        .baout     (baout),
        .reg_q     (reg_q),
        .r_out_sel (r_out_sel),
        .c_sign    (c_sign),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   ir;
        logic          gra, grb, grc, rout, baout;
        logic [NR-1:0] exp_sel;
        logic [DW-1:0] exp_c;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0; clr = 0;
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic logic [DW-1:0] slice(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    task automatic write_reg(input logic [31:0] ir_v, input logic a, input logic b,
                             input logic c, input int r, input logic [DW-1:0] v);
        idle();
        ir = ir_v; gra = a; grb = b; grc = c; rin = 1; bus_in = v;
        tick();
        model[r] = v;
        idle();
    endtask

    initial begin
        tbl[0] = '{32'h0180_0000, 1, 0, 0, 1, 0, 16'h0008, 32'h0000_0000};
        tbl[1] = '{32'h0038_0000, 0, 1, 0, 1, 0, 16'h0080, 32'h0000_0000};
        tbl[2] = '{32'h0007_8000, 0, 0, 1, 0, 1, 16'h8000, 32'hFFFF_8000};
        tbl[3] = '{32'h0007_FFFF, 0, 0, 0, 1, 0, 16'h0001, 32'hFFFF_FFFF};
        tbl[4] = '{32'h0003_FFFF, 0, 0, 0, 0, 0, 16'h0000, 32'h0003_FFFF};
        tbl[5] = '{32'h0148_0000, 1, 0, 0, 1, 0, 16'h0004, 32'h0000_0000};
        tbl[6] = '{32'h0148_0000, 0, 1, 0, 0, 1, 16'h0200, 32'h0000_0000};
        tbl[7] = '{32'h0280_0000, 1, 0, 0, 0, 0, 16'h0000, 32'h0000_0000};

        for (int i = 0; i < NR; i++) model[i] = '0;
        idle(); ir = '0; bus_in = '0;
        clr = 1;
        tick();
        clr = 0;
        check("reset_regs", reg_q, '0);
        check("reset_err", {511'b0, sel_err}, '0);

        for (int i = 0; i < 8; i++) begin
            ir = tbl[i].ir; gra = tbl[i].gra; grb = tbl[i].grb; grc = tbl[i].grc;
            rout = tbl[i].rout; baout = tbl[i].baout;
            #2;
            check($sformatf("tbl%0d_sel", i), {496'b0, r_out_sel}, {496'b0, tbl[i].exp_sel});
            check($sformatf("tbl%0d_csign", i), {480'b0, c_sign}, {480'b0, tbl[i].exp_c});
        end
        idle();

        // clr beats a same-cycle write
        write_reg(32'h0280_0000, 1, 0, 0, 5, 32'h0000_1234);
        check("preload_r5", {480'b0, slice(5)}, {480'b0, 32'h0000_1234});
        ir = 32'h0280_0000; gra = 1; rin = 1; bus_in = 32'hFFFF_FFFF; clr = 1;
        tick();
        idle();
        for (int i = 0; i < NR; i++) model[i] = '0;
        check("clr_prio_regs", reg_q, '0);
        check("clr_prio_err", {511'b0, sel_err}, '0);

        write_reg(32'h0180_0000, 1, 0, 0, 3, 32'hDEAD_BEEF);
        check("write_r3_all", reg_q, model_flat());
        ir = 32'h0180_0000; gra = 1; rout = 1;
        #2;
        check("read_r3_sel", {496'b0, r_out_sel}, {496'b0, 16'h0008});
        idle();

        write_reg(32'h0000_0000, 0, 0, 0, 0, 32'h0000_0055);
        check("write_r0_all", reg_q, model_flat());
        ir = 32'h0000_0000; gra = 1; baout = 1;
        #2;
        check("baout_sel", {496'b0, r_out_sel}, {496'b0, 16'h0001});
        check("baout_r0_zero", {480'b0, slice(0)}, '0);
        check("baout_r3_keep", {480'b0, slice(3)}, {480'b0, 32'hDEAD_BEEF});
        baout = 0; rout = 1;
        #2;
        check("rout_r0_val", {480'b0, slice(0)}, {480'b0, 32'h0000_0055});
        idle();

        write_reg(32'h0038_0000, 0, 1, 0, 7, 32'h0000_0010);
        ir = 32'h0038_0000; grb = 1; rout = 1; rin = 1; bus_in = 32'h0000_0011;
        #2;
        check("rmw_pre", {480'b0, slice(7)}, {480'b0, 32'h0000_0010});
        check("rmw_sel", {496'b0, r_out_sel}, {496'b0, 16'h0080});
        tick();
        idle();
        model[7] = 32'h0000_0011;
        check("rmw_post_all", reg_q, model_flat());
        check("no_err_yet", {511'b0, sel_err}, '0);

        ir = 32'h0000_0000; gra = 1; grb = 1; rin = 1; bus_in = 32'h0000_00AA;
        tick();
        idle();
        check("conflict_set", {511'b0, sel_err}, {511'b0, CONF});
        tick(); tick();
        check("conflict_sticky", {511'b0, sel_err}, {511'b0, CONF});
        clr = 1;
        tick();
        idle();
        for (int i = 0; i < NR; i++) model[i] = '0;
        check("conflict_clr", {511'b0, sel_err}, '0);
        check("clr_regs2", reg_q, '0);

        ir = 32'h0180_0000; gra = 1; rout = 1; baout = 1;
        tick();
        idle();
        check("rout_baout_err", {511'b0, sel_err}, {511'b0, CONF});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/sel_enc_regfile.md
Name: sel_enc_regfile

Overview:
- Receiving end of the shared 32-bit datapath bus, and the source of the per-register output selects (r0o..r15o) that the bus driver mux consumes.
- Holds the 16 general-purpose registers R0..R15.
- Decodes the ra/rb/rc fields of the IR under Gra/Grb/Grc into a one-hot register index, then gates it with Rin (load from bus) and Rout/BAout (drive onto bus).
- Also produces the sign-extended C constant (busi_c_sign) and a sticky select-conflict flag.

Parameters:
- DATA_W, 32, bus and register width.
- NREG, 16, number of GPRs. Fixed by the 4-bit IR register fields; other values are unsupported.
- C_W, 19, width of the IR C field that is sign-extended.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-high.
- bus_in  in  DATA_W  current bus value (driver mux output).
- ir  in  32  instruction register contents.
- gra  in  1  select ra field, ir[26:23].
- grb  in  1  select rb field, ir[22:19].
- grc  in  1  select rc field, ir[18:15].
- rin  in  1  load selected register from bus_in at clock edge.
- rout  in  1  request selected register onto bus.
- baout  in  1  base-address out: like rout, but R0 reads as zero.
- reg_q  out  NREG*DATA_W  flat register values; R(i) at [i*DATA_W +: DATA_W].
- r_out_sel  out  NREG  one-hot drive selects to the bus mux (bit i -> ri_o).
- c_sign  out  DATA_W  ir[C_W-1:0] sign-extended to DATA_W.
- sel_err  out  1  sticky select-conflict flag.

Behaviour:
- Reset: on clk edge with clr=1, all R0..R15 = 0 and sel_err = 0. clr has priority over any rin write in the same cycle.
- Index decode (combinational): idx = (ra & {4{gra}}) | (rb & {4{grb}}) | (rc & {4{grc}}). dec = one-hot(idx).
  - No G line asserted: idx = 0, which selects R0 if rin/rout are set. This is intentional, not an error.
- Write:
  - On clk edge with rin=1 and clr=0, R[idx] <= bus_in. Exactly one register is written.
  - R0 is writable (not hardwired to zero).
  - Latency: written value is visible on reg_q the cycle after the edge.
- Read selects: r_out_sel = dec & {NREG{rout | baout}}. Combinational, zero latency from gra/grb/grc/rout/baout/ir.
- BAout: while baout=1 and idx=0, the R0 slice of reg_q reads 0. The stored R0 is unchanged, and reg_q bit 0 slice shows the stored value whenever baout=0. Other registers are unaffected by baout.
- Simultaneous rin and rout on the same index: bus carries the old value (reg_q is pre-edge), and the register captures bus_in at the edge. No hazard logic is needed.
- c_sign = {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]}. Combinational.
- sel_err: set at clk edge when any of the following holds, and cleared only by clr:
  - (rin | rout | baout) and more than one of gra/grb/grc is asserted; or
  - rout and baout are both asserted.

Optional Feature:
- Macro: SEL_ENC_CONFLICT_CHECK_EN.
- Defined: sel_err logic is built as specified above.
- Undefined: sel_err is tied to 0 with no state. The OR-of-fields decode is unchanged in both builds.

Decomposition:
- Shared package holds:
  - IR field positions: RA_MSB/LSB = 26/23, RB = 22/19, RC = 18/15.
  - C_W, DATA_W, NREG.
- One natural sub-module: sel_enc_decode, the combinational G-gating, 4-to-16 one-hot decode and c_sign. The register array and sel_err live in the top.

Test Plan:
- Reset: preload R5=0x1234; assert clr with rin=1 and bus_in=0xFFFFFFFF -> all reg_q = 0 and sel_err = 0 next cycle.
- Write/read: ir ra=3, gra=1, rin=1, bus_in=0xDEADBEEF for one cycle -> R3 = 0xDEADBEEF and no other register changes; then rout=1 -> r_out_sel = 0x0008.
- BAout: R0=0x55; ir ra=0, gra=1, baout=1 -> r_out_sel = 0x0001 and R0 slice = 0; baout=0, rout=1 -> R0 slice = 0x55.
- Read-modify-write: R7=0x10; ir rb=7, grb=1, rout=1 and rin=1 with bus_in=0x11 -> reg_q R7 = 0x10 during the cycle, 0x11 after the edge.
- c_sign: ir[18:0]=0x7FFFF -> 0xFFFFFFFF; ir[18:0]=0x3FFFF -> 0x0003FFFF.
- Conflict (macro defined): gra=grb=1 with rin=1 for one cycle -> sel_err = 1 next cycle and it stays 1 until clr. Macro undefined: sel_err stays 0.
